// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard controller with a per-register load-latency scoreboard.
// It arbitrates dmem, redirect, load-use and icache hazards into latch enables and flushes.
module hazard_scoreboard_unit #(
    parameter int NREGS        = 32,
    parameter int REGW         = 5,
    parameter int LOAD_LAT     = 1,
    parameter int BRANCH_STAGE = 3,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_req,
    input  logic             dec_valid,
    input  logic [REGW-1:0]  dec_rs,
    input  logic [REGW-1:0]  dec_rt,
    input  logic             dec_uses_rs,
    input  logic             dec_uses_rt,
    input  logic             dec_wr_en,
    input  logic [REGW-1:0]  dec_wr_addr,
    input  logic             dec_is_load,
    input  logic             redirect,
    output logic             pc_en,
    output logic [3:0]       stage_en,
    output logic [3:0]       stage_flush,
    output logic             hazard,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int PW = $clog2(LOAD_LAT + 1);
    localparam logic [PW-1:0] LAT = PW'(LOAD_LAT);

    typedef enum logic [2:0] {
        C_DMEM,
        C_REDIRECT,
        C_LOAD_USE,
        C_ICACHE,
        C_NONE
    } hz_case_e;

    logic [PW-1:0] pend     [NREGS];
    logic [PW-1:0] pend_nxt [NREGS];
    hz_case_e      sel;
    logic          load_use;
    logic          advance;
    logic          issue_load;

    assign load_use = dec_valid &&
        ((dec_uses_rs && dec_rs != '0 && pend[dec_rs] != '0) ||
         (dec_uses_rt && dec_rt != '0 && pend[dec_rt] != '0));

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        sel = C_NONE;
        if (mem_req && !dhit) sel = C_DMEM;
        else if (redirect)    sel = C_REDIRECT;
        else if (load_use)    sel = C_LOAD_USE;
        else if (!ihit)       sel = C_ICACHE;
    end

    assign advance    = (sel != C_DMEM);
    assign issue_load = (sel == C_NONE) && dec_valid && dec_is_load &&
                        dec_wr_en && (dec_wr_addr != '0);

    always_comb begin
        pc_en       = 1'b1;
        stage_en    = 4'b1111;
        stage_flush = 4'b0000;
        hazard      = 1'b0;
        if (RST) begin
            stage_flush = 4'b1111;
        end else begin
            hazard = (sel != C_NONE);
            unique case (sel)
                C_DMEM: begin
                    pc_en    = 1'b0;
                    stage_en = 4'b0000;
                end
                C_REDIRECT: begin
                    stage_flush = (BRANCH_STAGE == 3) ? 4'b0111 : 4'b0011;
                end
                C_LOAD_USE, C_ICACHE: begin
                    pc_en       = 1'b0;
                    stage_en    = 4'b1110;
                    stage_flush = 4'b0010;
                end
                default: ;
            endcase
        end
    end

    // A redirect from memory squashes the load sitting in EX, whose entry still holds LAT.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            pend_nxt[r] = pend[r];
            if (advance) begin
                if (pend[r] != '0) pend_nxt[r] = pend[r] - 1'b1;
                if (sel == C_REDIRECT && BRANCH_STAGE == 3 && pend[r] == LAT)
                    pend_nxt[r] = '0;
            end
        end
        if (issue_load) pend_nxt[dec_wr_addr] = LAT;
        pend_nxt[0] = '0;
    end

    // NOTE: the scoreboard array is reset explicitly; stale pending loads must not survive RST.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < NREGS; r++) pend[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) pend[r] <= pend_nxt[r];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (sel == C_REDIRECT && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench: three configurations share one stimulus stream; each phase checks
// the configuration whose parameters it exercises against hand-computed values.
module tb_hazard_scoreboard_unit;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ihit, dhit, mem_req, dec_valid;
    logic [4:0] dec_rs, dec_rt, dec_wr_addr;
    logic       dec_uses_rs, dec_uses_rt, dec_wr_en, dec_is_load, redirect;

    // a: LOAD_LAT=1, BRANCH_STAGE=3; b: LOAD_LAT=2, BRANCH_STAGE=2; c: CNT_W=4
    logic        a_pc_en, b_pc_en, c_pc_en;
    logic [3:0]  a_en, b_en, c_en, a_fl, b_fl, c_fl;
    logic        a_hz, b_hz, c_hz;
    logic [15:0] a_sc, a_fc, b_sc, b_fc;
    logic [3:0]  c_sc, c_fc;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    hazard_scoreboard_unit #(.LOAD_LAT(1), .BRANCH_STAGE(3)) dut_a (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt), .dec_wr_en(dec_wr_en),
        .dec_wr_addr(dec_wr_addr), .dec_is_load(dec_is_load), .redirect(redirect),
        .pc_en(a_pc_en), .stage_en(a_en), .stage_flush(a_fl), .hazard(a_hz),
        .stall_cnt(a_sc), .flush_cnt(a_fc));

    hazard_scoreboard_unit #(.LOAD_LAT(2), .BRANCH_STAGE(2)) dut_b (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt), .dec_wr_en(dec_wr_en),
        .dec_wr_addr(dec_wr_addr), .dec_is_load(dec_is_load), .redirect(redirect),
        .pc_en(b_pc_en), .stage_en(b_en), .stage_flush(b_fl), .hazard(b_hz),
        .stall_cnt(b_sc), .flush_cnt(b_fc));

    hazard_scoreboard_unit #(.CNT_W(4)) dut_c (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt), .dec_wr_en(dec_wr_en),
        .dec_wr_addr(dec_wr_addr), .dec_is_load(dec_is_load), .redirect(redirect),
        .pc_en(c_pc_en), .stage_en(c_en), .stage_flush(c_fl), .hazard(c_hz),
        .stall_cnt(c_sc), .flush_cnt(c_fc));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b1; mem_req = 1'b0; redirect = 1'b0;
        dec_valid = 1'b0; dec_rs = '0; dec_rt = '0; dec_uses_rs = 1'b0;
        dec_uses_rt = 1'b0; dec_wr_en = 1'b0; dec_wr_addr = '0; dec_is_load = 1'b0;
    endtask

    task automatic dec_op(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic wr, input logic [4:0] wa,
                          input logic ld);
        dec_valid = 1'b1; dec_rs = rs; dec_rt = rt; dec_uses_rs = urs;
        dec_uses_rt = urt; dec_wr_en = wr; dec_wr_addr = wa; dec_is_load = ld;
    endtask

    task automatic do_reset(input string tag);
        idle();
        RST = 1'b1;
        #1;
        check({tag, "_rst_pc_en"}, a_pc_en, 1);
        check({tag, "_rst_en"}, a_en, 4'b1111);
        check({tag, "_rst_flush"}, a_fl, 4'b1111);
        check({tag, "_rst_hazard"}, a_hz, 0);
        tick();
        RST = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        // Reset held two cycles, then idle
        idle();
        RST = 1'b1;
        tick();
        do_reset("p1");
        #1;
        check("idle_pc_en", a_pc_en, 1);
        check("idle_en", a_en, 4'b1111);
        check("idle_flush", a_fl, 4'b0000);
        check("idle_hazard", a_hz, 0);
        check("idle_stall_cnt", a_sc, 0);
        tick();

        // Load to r5, then reader of r5: a stalls 1 cycle, b stalls 2
        dec_op(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1); #1;
        check("lw_issue_a", a_pc_en, 1);
        check("lw_issue_b", b_pc_en, 1);
        tick();
        dec_op(5'd5, 5'd2, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0); #1;
        check("lu1_a_pc_en", a_pc_en, 0);
        check("lu1_a_en", a_en, 4'b1110);
        check("lu1_a_flush", a_fl, 4'b0010);
        check("lu1_a_hazard", a_hz, 1);
        check("lu1_b_pc_en", b_pc_en, 0);
        tick(); #1;
        check("lu2_a_pc_en", a_pc_en, 1);
        check("lu2_b_pc_en", b_pc_en, 0);
        check("lu2_b_flush", b_fl, 4'b0010);
        tick(); #1;
        check("lu3_b_pc_en", b_pc_en, 1);
        check("lu_a_stall_cnt", a_sc, 1);
        check("lu_b_stall_cnt", b_sc, 2);
        tick();

        // r0 never pending; unused rt never stalls
        dec_op(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1); tick();
        dec_op(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0); #1;
        check("r0_reader_a", a_pc_en, 1);
        check("r0_reader_b", b_pc_en, 1);
        tick();
        dec_op(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b1); tick();
        dec_op(5'd1, 5'd6, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0); #1;
        check("rt_unused_a", a_pc_en, 1);
        check("rt_unused_b", b_pc_en, 1);
        tick();
        dec_op(5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0); #1;
        check("rt_used_a", a_pc_en, 1);
        check("rt_used_b", b_pc_en, 0);
        tick();

        // Redirect squashes a load just issued into EX
        do_reset("p4");
        dec_op(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1); tick();
        dec_op(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0);
        redirect = 1'b1; #1;
        check("rd_a_pc_en", a_pc_en, 1);
        check("rd_a_en", a_en, 4'b1111);
        check("rd_a_flush", a_fl, 4'b0111);
        check("rd_a_hazard", a_hz, 1);
        check("rd_b_flush", b_fl, 4'b0011);
        tick();
        redirect = 1'b0; #1;
        check("rd_r7_reader_a", a_pc_en, 1);
        check("rd_r7_reader_b", b_pc_en, 0);
        check("rd_a_flush_cnt", a_fc, 1);
        check("rd_b_flush_cnt", b_fc, 1);
        tick();

        // dmem stall over a pending redirect and load-use
        do_reset("p5");
        dec_op(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1); tick();
        dec_op(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0);
        redirect = 1'b1; mem_req = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("dm%0d_a_en", i), a_en, 4'b0000);
            check($sformatf("dm%0d_a_flush", i), a_fl, 4'b0000);
            check($sformatf("dm%0d_a_pc_en", i), a_pc_en, 0);
            check($sformatf("dm%0d_a_hazard", i), a_hz, 1);
            tick();
        end
        dhit = 1'b1; #1;
        check("dm_release_a_flush", a_fl, 4'b0111);
        check("dm_release_a_pc_en", a_pc_en, 1);
        check("dm_release_b_flush", b_fl, 4'b0011);
        tick();
        redirect = 1'b0; mem_req = 1'b0; #1;
        check("dm_after_a_pc_en", a_pc_en, 1);
        check("dm_frozen_b_pc_en", b_pc_en, 0);
        check("dm_a_stall_cnt", a_sc, 3);
        check("dm_a_flush_cnt", a_fc, 1);
        tick();

        // Reset mid-stall discards pending state
        do_reset("p7");
        dec_op(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1); tick();
        dec_op(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0);
        RST = 1'b1; #1;
        check("mid_rst_pc_en", a_pc_en, 1);
        check("mid_rst_flush", a_fl, 4'b1111);
        check("mid_rst_hazard", a_hz, 0);
        tick();
        RST = 1'b0; #1;
        check("post_rst_pc_en", a_pc_en, 1);
        check("post_rst_stall_cnt", a_sc, 0);
        tick();

        // Icache misses saturate the 4-bit counter
        do_reset("p6");
        ihit = 1'b0; #1;
        check("ic_c_pc_en", c_pc_en, 0);
        check("ic_c_flush", c_fl, 4'b0010);
        check("ic_c_en", c_en, 4'b1110);
        for (int i = 0; i < 20; i++) tick();
        ihit = 1'b1; #1;
        check("sat_c_stall_cnt", c_sc, 15);
        check("sat_a_stall_cnt", a_sc, 20);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
